cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CORE_LAT, default 2, clock cycles from core_angle stable to core_x/core_y valid.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester request.
REQ-006 SHALL have port req_angle, input, 20*N_REQ, flattened signed Q16.4 degree angles; slice i is requester i.
REQ-007 SHALL have port req_ready, output, N_REQ, one-hot accept strobe.
REQ-008 SHALL have port core_angle, output, 20, signed Q16.4 angle driven to the sin/cos core.
REQ-009 SHALL have ports core_x and core_y, input, 20 each, signed Q4.16 core results.
REQ-010 SHALL have port rsp_valid, output, 1, response available.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-012 SHALL have port rsp_id, output, clog2(N_REQ), requester index of the response.
REQ-013 SHALL have ports rsp_cos and rsp_sin, output, 20 each, signed Q4.16 results.
REQ-014 SHALL have port rsp_err, output, 1, input angle out of range.

Function
REQ-015 SHALL run an FSM with states IDLE, WAIT, CAPT, RESP; one transaction in flight.
REQ-016 In IDLE with any req_valid high, SHALL grant one requester round-robin, starting from (last_grant+1) mod N_REQ.
REQ-017 SHALL assert req_ready[g] for exactly that one cycle; the handshake completes on the same edge, which captures the angle, id and fold flag.
REQ-018 SHALL keep req_ready all-zero in every state other than IDLE.
REQ-019 SHALL range-check |angle| <= 2880 (180 deg); out of range -> RESP directly, rsp_err=1, rsp_cos=rsp_sin=0.
REQ-020 SHALL fold in-range angles to core range:
- a > 1440: core angle a-2880, neg=1
- a < -1440: core angle a+2880, neg=1
- otherwise: core angle a, neg=0
- exactly +/-1440: not folded.
REQ-021 SHALL drive core_angle from a register, held constant from the accept edge until leaving CAPT; reset value 0.
REQ-022 WAIT SHALL count CORE_LAT cycles, then go to CAPT; CAPT SHALL sample core_x/core_y on its edge and go to RESP.
REQ-023 On that CAPT edge, SHALL set rsp_cos=core_x and rsp_sin=core_y, each two's-complement negated when neg=1, 20-bit wrap.
REQ-024 Accept-edge to rsp_valid-high latency SHALL be CORE_LAT+2 cycles for in-range angles and 1 cycle for errors.
REQ-025 In RESP, SHALL hold rsp_valid and all rsp_* stable until rsp_ready=1, then go to IDLE; no new grant on that edge.
REQ-026 A requester dropping req_valid before its grant SHALL simply lose arbitration; no state change.
REQ-027 SHALL update last_grant only on a grant edge.

Reset
REQ-028 rst=0 SHALL force state IDLE, last_grant=N_REQ-1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_cos=rsp_sin=0, core_angle=0, wait counter 0.
REQ-029 Reset mid-transaction SHALL discard it silently; the first grant after reset SHALL go to the lowest-index valid requester from 0 upward.

Structure
REQ-030 Shared package SHALL hold the fixed-point constants: ANG_90=1440, ANG_180=2880, angle/result widths 20, and the FSM state encoding.
REQ-031 Round-robin selection SHALL be one sub-module, rr_arbiter, inputs req and last_grant, outputs one-hot grant and index.

Verification
REQ-032 Single request, id 0, angle 480 (30 deg) -> rsp_valid 4 cycles after accept; rsp_id=0; rsp_cos ~56756, rsp_sin ~32768, within +/-330 LSB.
REQ-033 Angle 2400 (150 deg) -> core_angle=-480; rsp_cos ~-56756, rsp_sin ~+32768; angle -1440 -> core_angle=-1440, neg=0.
REQ-034 All 4 req_valid held high -> grant order 0,1,2,3,0 with each req_ready a single-cycle pulse.
REQ-035 Angle 2881 -> rsp_err=1, rsp_cos=rsp_sin=0, rsp_valid 1 cycle after accept, core_angle unchanged.
REQ-036 rsp_ready low for 5 cycles in RESP -> outputs stable and no req_ready; rst=0 asserted during WAIT -> next cycle rsp_valid=0, state IDLE, and requester 0 is served first.

Source files
------------

// File: rtl/cordic_arbiter_pkg.sv
// Shared constants, FSM encoding and angle folding for the CORDIC request arbiter.
// Angles are signed Q16.4 degrees; results are signed Q4.16.
package cordic_arbiter_pkg;

    localparam int ANG_W = 20;
    localparam int RES_W = 20;

    localparam logic signed [ANG_W-1:0] ANG_90  = 20'sd1440;
    localparam logic signed [ANG_W-1:0] ANG_180 = 20'sd2880;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic                    err;
        logic                    neg;
        logic signed [ANG_W-1:0] angle;
    } fold_t;

    // Map a request angle onto the core's +/-90 degree range. A 180 degree shift
    // negates both sin and cos, so the caller only has to remember the neg flag.
    function automatic fold_t fold_angle(input logic signed [ANG_W-1:0] a);
        fold_t f;
        f.err   = (a > ANG_180) || (a < -ANG_180);
        f.neg   = 1'b0;
        f.angle = a;
        if (a > ANG_90) begin
            f.angle = a - ANG_180;
            f.neg   = 1'b1;
        end else if (a < -ANG_90) begin
            f.angle = a + ANG_180;
            f.neg   = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/cordic_arbiter_rr.sv
// Round-robin pick: the first asserted request strictly after last_grant, wrapping
// modulo N_REQ, so the previous winner has the lowest priority.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int            k;
    logic [IW-1:0] ki;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        ki    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            k  = (int'(last_grant) + off) % N_REQ;
            ki = IW'(k);
            if (!any && req[ki]) begin
                any       = 1'b1;
                grant[ki] = 1'b1;
                idx       = ki;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one fixed-latency sin/cos core among N_REQ requesters, one transaction at a time.
// Handshakes: a side transfers on a rising edge where its valid and ready are both high.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int CORE_LAT = 2,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [ANG_W*N_REQ-1:0] req_angle,
    output logic [N_REQ-1:0]       req_ready,
    output logic [ANG_W-1:0]       core_angle,
    input  logic [RES_W-1:0]       core_x,
    input  logic [RES_W-1:0]       core_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [RES_W-1:0]       rsp_cos,
    output logic [RES_W-1:0]       rsp_sin,
    output logic                   rsp_err,
    output state_t                 dbg_state
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_t                  state;
    logic [IW-1:0]           last_grant;
    logic [CW-1:0]           wait_cnt;
    logic                    neg;
    logic [N_REQ-1:0]        grant;
    logic [IW-1:0]           grant_idx;
    logic                    grant_any;
    logic signed [ANG_W-1:0] sel_angle;
    fold_t                   fold;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .idx        (grant_idx),
        .any        (grant_any)
    );

    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == grant_idx) sel_angle = req_angle[i*ANG_W +: ANG_W];
        end
    end

    assign fold = fold_angle(sel_angle);

    // The grant is only offered while idle; leaving IDLE on the accept edge makes it a one-cycle pulse.
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= IW'(N_REQ - 1);
            wait_cnt   <= '0;
            neg        <= 1'b0;
            core_angle <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= '0;
            rsp_cos    <= '0;
            rsp_sin    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_idx;
                        rsp_id     <= grant_idx;
                        if (fold.err) begin
                            // Out-of-range angles never touch the core; core_angle keeps its old value.
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_cos   <= '0;
                            rsp_sin   <= '0;
                        end else begin
                            state      <= ST_WAIT;
                            core_angle <= fold.angle;
                            neg        <= fold.neg;
                            wait_cnt   <= '0;
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == CW'(CORE_LAT - 1)) begin
                        state    <= ST_CAPT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_CAPT: begin
                    rsp_cos   <= neg ? -core_x : core_x;
                    rsp_sin   <= neg ? -core_y : core_y;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a table-driven stand-in for the sin/cos core
// whose output follows core_angle exactly two cycles later.
module tb_cordic_arbiter;
    import cordic_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [79:0] req_angle;
    logic [3:0]  req_ready;
    logic [19:0] core_angle;
    logic [19:0] core_x;
    logic [19:0] core_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [19:0] rsp_cos;
    logic [19:0] rsp_sin;
    logic        rsp_err;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] C30   = 20'd56756;
    localparam logic [19:0] S30   = 20'd32768;
    localparam logic [19:0] M_C30 = 20'(-56756);
    localparam logic [19:0] M_S30 = 20'(-32768);
    localparam logic [19:0] ONE   = 20'd65536;
    localparam logic [19:0] M_ONE = 20'(-65536);

    cordic_arbiter #(.N_REQ(4), .CORE_LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .core_angle (core_angle),
        .core_x     (core_x),
        .core_y     (core_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_cos    (rsp_cos),
        .rsp_sin    (rsp_sin),
        .rsp_err    (rsp_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- core model ----------------
    function automatic logic [19:0] lut_cos(input logic [19:0] a);
        case (a)
            20'h001E0, 20'hFFE20: return C30;   // +/-30 deg
            20'h005A0, 20'hFFA60: return 20'd0; // +/-90 deg
            20'h00000:            return ONE;
            default:              return 20'h0ABCD;
        endcase
    endfunction

    function automatic logic [19:0] lut_sin(input logic [19:0] a);
        case (a)
            20'h001E0: return S30;
            20'hFFE20: return M_S30;
            20'h005A0: return ONE;
            20'hFFA60: return M_ONE;
            20'h00000: return 20'd0;
            default:   return 20'h01234;
        endcase
    endfunction

    logic [19:0] core_p1, core_p2;
    always @(posedge clk) begin
        core_p1 <= core_angle;
        core_p2 <= core_p1;
    end
    assign core_x = lut_cos(core_p2);
    assign core_y = lut_sin(core_p2);

    // ---------------- driver tasks ----------------
    task automatic apply_reset;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one transaction from a single requester and reports what was observed.
    task automatic do_txn(input int id, input logic [19:0] ang, output int lat,
                          output logic [19:0] cang, output logic [19:0] rc,
                          output logic [19:0] rs, output logic re, output int rid);
        int n;
        req_angle[id*20 +: 20] = ang;
        req_valid[id]          = 1'b1;
        n = 0;
        #1;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready[id]) begin
            checks++; errors++;
            $display("FAIL grant_timeout id=%0d: got req_ready=%b want bit %0d", id, req_ready, id);
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
        cang = core_angle;
        lat  = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        rc  = rsp_cos;
        rs  = rsp_sin;
        re  = rsp_err;
        rid = int'(rsp_id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        apply_reset();
        #1;
        checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0)    begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (core_angle !== 20'd0)  begin errors++; $display("FAIL reset_core_angle: got %h want 0", core_angle); end
        checks++; if (rsp_id !== 2'd0)       begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0)      begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (rsp_cos !== 20'd0 || rsp_sin !== 20'd0) begin errors++; $display("FAIL reset_rsp_data: got %h/%h want 0/0", rsp_cos, rsp_sin); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_single;
        int lat, rid; logic [19:0] cang, rc, rs; logic re;
        do_txn(0, 20'd480, lat, cang, rc, rs, re, rid);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
        checks++; if (rid !== 0)       begin errors++; $display("FAIL single_id: got %0d want 0", rid); end
        checks++; if (cang !== 20'd480) begin errors++; $display("FAIL single_core_angle: got %h want %h", cang, 20'd480); end
        checks++; if (rc !== C30)      begin errors++; $display("FAIL single_cos: got %h want %h", rc, C30); end
        checks++; if (rs !== S30)      begin errors++; $display("FAIL single_sin: got %h want %h", rs, S30); end
        checks++; if (re !== 1'b0)     begin errors++; $display("FAIL single_err: got %b want 0", re); end
    endtask

    task automatic test_fold;
        logic [19:0] ang[5], ecang[5], ec[5], es[5];
        int lat, rid; logic [19:0] cang, rc, rs; logic re;
        ang[0] = 20'd2400;     ecang[0] = 20'(-480);  ec[0] = M_C30;  es[0] = S30;
        ang[1] = 20'(-1440);   ecang[1] = 20'(-1440); ec[1] = 20'd0;  es[1] = M_ONE;
        ang[2] = 20'(-2400);   ecang[2] = 20'd480;    ec[2] = M_C30;  es[2] = M_S30;
        ang[3] = 20'd2880;     ecang[3] = 20'd0;      ec[3] = M_ONE;  es[3] = 20'd0;
        ang[4] = 20'd1440;     ecang[4] = 20'd1440;   ec[4] = 20'd0;  es[4] = ONE;
        for (int i = 0; i < 5; i++) begin
            do_txn((i + 1) % 4, ang[i], lat, cang, rc, rs, re, rid);
            checks++; if (cang !== ecang[i]) begin errors++; $display("FAIL fold_core_angle[%0d]: got %h want %h", i, cang, ecang[i]); end
            checks++; if (rc !== ec[i])      begin errors++; $display("FAIL fold_cos[%0d]: got %h want %h", i, rc, ec[i]); end
            checks++; if (rs !== es[i])      begin errors++; $display("FAIL fold_sin[%0d]: got %h want %h", i, rs, es[i]); end
            checks++; if (rid !== (i + 1) % 4) begin errors++; $display("FAIL fold_id[%0d]: got %0d want %0d", i, rid, (i + 1) % 4); end
            checks++; if (lat !== 4 || re !== 1'b0) begin errors++; $display("FAIL fold_timing[%0d]: got lat=%0d err=%b want 4/0", i, lat, re); end
        end
    endtask

    task automatic test_error;
        int lat, rid; logic [19:0] cang, rc, rs; logic re;
        logic [19:0] bad[2];
        bad[0] = 20'd2881;
        bad[1] = 20'(-2881);
        do_txn(1, 20'd480, lat, cang, rc, rs, re, rid);
        for (int i = 0; i < 2; i++) begin
            do_txn(2 + i, bad[i], lat, cang, rc, rs, re, rid);
            checks++; if (re !== 1'b1)      begin errors++; $display("FAIL err_flag[%0d]: got %b want 1", i, re); end
            checks++; if (lat !== 1)        begin errors++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
            checks++; if (rc !== 20'd0 || rs !== 20'd0) begin errors++; $display("FAIL err_data[%0d]: got %h/%h want 0/0", i, rc, rs); end
            checks++; if (cang !== 20'd480) begin errors++; $display("FAIL err_core_angle[%0d]: got %h want %h", i, cang, 20'd480); end
            checks++; if (rid !== 2 + i)    begin errors++; $display("FAIL err_id[%0d]: got %0d want %0d", i, rid, 2 + i); end
        end
    endtask

    task automatic test_round_robin;
        int n, exp_id;
        apply_reset();
        for (int i = 0; i < 4; i++) req_angle[i*20 +: 20] = 20'd480;
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_id = t % 4;
            n = 0;
            #1;
            while (req_ready == 4'b0 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            checks++; if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, 4'b0001 << exp_id); end
            @(negedge clk); #1;
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rr_pulse[%0d]: got %b want 0000", t, req_ready); end
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk); n++;
            end
            checks++; if (rsp_id !== 2'(exp_id) || rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d valid=%b want %0d", t, rsp_id, rsp_valid, exp_id); end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        req_valid = 4'b0;
    endtask

    task automatic test_backpressure;
        int n;
        req_angle[2*20 +: 20] = 20'd2400;
        req_valid = 4'b0100;
        n = 0;
        #1;
        while (!req_ready[2] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        req_valid = 4'b1011;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
            checks++; if (rsp_cos !== M_C30 || rsp_sin !== S30 || rsp_id !== 2'd2) begin errors++; $display("FAIL bp_data[%0d]: got %h/%h id %0d want %h/%h id 2", c, rsp_cos, rsp_sin, rsp_id, M_C30, S30); end
            checks++; if (req_ready !== 4'b0 || dbg_state !== ST_RESP) begin errors++; $display("FAIL bp_hold[%0d]: got ready=%b state=%0d want 0000/RESP", c, req_ready, dbg_state); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL bp_release: got valid=%b state=%0d want 0/IDLE", rsp_valid, dbg_state); end
    endtask

    task automatic test_reset_mid;
        int n;
        req_angle[2*20 +: 20] = 20'd480;
        req_valid = 4'b0100;
        n = 0;
        #1;
        while (!req_ready[2] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL mid_in_wait: got %0d want WAIT", dbg_state); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_reset: got valid=%b state=%0d want 0/IDLE", rsp_valid, dbg_state); end
        checks++; if (core_angle !== 20'd0) begin errors++; $display("FAIL mid_core_angle: got %h want 0", core_angle); end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) req_angle[i*20 +: 20] = 20'd480;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        checks++; if (n !== 4 || rsp_id !== 2'd0 || rsp_cos !== C30) begin errors++; $display("FAIL mid_first_rsp: got lat=%0d id=%0d cos=%h want 4/0/%h", n, rsp_id, rsp_cos, C30); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_fold();
        test_error();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
